// File: rtl/data_memory_responder.sv
// Data-memory responder for the single-cycle core: byte-lane word RAM plus an MMIO
// page with console TX FIFO, cycle counter, halt register and sticky error flags.
`timescale 1ns/1ps

package data_memory_responder_pkg;
  typedef enum logic [1:0] {
    MEM_BYTE     = 2'd0,
    MEM_HALFWORD = 2'd1,
    MEM_WORD     = 2'd2
  } memory_mask_t;
endpackage

module data_memory_responder
  import data_memory_responder_pkg::*;
#(
  parameter int unsigned RAM_WORDS  = 1024,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [31:0] MMIO_BASE  = 32'hFFFF_FF00
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [31:0]  memory_address,
  input  logic [31:0]  memory_write,
  input  memory_mask_t memory_mask,
  input  logic         memory_we,
  output logic [31:0]  memory_out,
  output logic [7:0]   tx_data,
  output logic         tx_valid,
  input  logic         tx_ready,
  output logic         halted,
  output logic [7:0]   exit_code,
  output logic         err_misaligned,
  output logic         err_unmapped,
  output logic         fifo_overflow
);

  localparam int unsigned AW = $clog2(RAM_WORDS);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;

  localparam logic [1:0] OFF_CONSOLE = 2'd0;
  localparam logic [1:0] OFF_STATUS  = 2'd1;
  localparam logic [1:0] OFF_CYCLE   = 2'd2;
  localparam logic [1:0] OFF_HALT    = 2'd3;

  logic          aligned;
  logic          ram_hit;
  logic          mmio_hit;
  logic          mmio_word;
  logic [1:0]    mmio_off;
  logic [3:0]    lane_en;
  logic [4:0]    byte_shift;
  logic [31:0]   wdata_lanes;
  logic [AW-1:0] ram_idx;

  logic wr_ok;
  logic ram_wr;
  logic mmio_wr;
  logic console_push;
  logic cycle_wr;
  logic halt_wr;
  logic set_mis;
  logic set_unm;

  logic [31:0] ram [RAM_WORDS];
  logic [31:0] ram_word;
  logic [31:0] ram_shifted;
  logic [31:0] ram_rdata;
  logic [31:0] mmio_rdata;
  logic [31:0] status_word;
  logic [31:0] cycle_count;

  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] fifo_count;
  logic [CW-1:0] count_next;
  logic          fifo_full;
  logic          fifo_empty;
  logic          fifo_pop;
  logic          push_accept;

  // Access decode: alignment, region and byte lanes
  always_comb begin
    aligned = 1'b0;
    lane_en = 4'b0000;
    case (memory_mask)
      MEM_BYTE: begin
        aligned = 1'b1;
        lane_en = 4'b0001 << memory_address[1:0];
      end
      MEM_HALFWORD: begin
        aligned = ~memory_address[0];
        lane_en = memory_address[1] ? 4'b1100 : 4'b0011;
      end
      MEM_WORD: begin
        aligned = (memory_address[1:0] == 2'b00);
        lane_en = 4'b1111;
      end
      default: begin
        aligned = 1'b0;
        lane_en = 4'b0000;
      end
    endcase
  end

  assign ram_hit     = (memory_address[31:AW+2] == '0);
  assign mmio_hit    = (memory_address[31:4] == MMIO_BASE[31:4]);
  assign mmio_word   = mmio_hit && (memory_mask == MEM_WORD);
  assign mmio_off    = memory_address[3:2];
  assign byte_shift  = {memory_address[1:0], 3'b000};
  assign wdata_lanes = memory_write << byte_shift;
  assign ram_idx     = memory_address[AW+1:2];

  // Write qualification; misalignment wins over region decode
  assign wr_ok        = memory_we && aligned;
  assign ram_wr       = wr_ok && ram_hit;
  assign mmio_wr      = wr_ok && mmio_word;
  assign console_push = mmio_wr && (mmio_off == OFF_CONSOLE);
  assign cycle_wr     = mmio_wr && (mmio_off == OFF_CYCLE);
  assign halt_wr      = mmio_wr && (mmio_off == OFF_HALT);
  assign set_mis      = memory_we && !aligned;
  assign set_unm      = wr_ok && !ram_hit && !mmio_word;

  // RAM storage is intentionally not reset
  always_ff @(posedge clk) begin
    if (ram_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (lane_en[b]) ram[ram_idx][8*b +: 8] <= wdata_lanes[8*b +: 8];
      end
    end
  end

  // Combinational read path
  always_comb begin
    ram_word    = ram[ram_idx];
    ram_shifted = ram_word >> byte_shift;
    ram_rdata   = '0;
    case (memory_mask)
      MEM_BYTE:     ram_rdata = {24'b0, ram_shifted[7:0]};
      MEM_HALFWORD: ram_rdata = {16'b0, ram_shifted[15:0]};
      MEM_WORD:     ram_rdata = ram_shifted;
      default:      ram_rdata = '0;
    endcase
  end

  assign status_word = {13'b0, err_unmapped, err_misaligned, fifo_overflow,
                        8'(fifo_count), 6'b0, fifo_empty, fifo_full};

  always_comb begin
    mmio_rdata = '0;
    case (mmio_off)
      OFF_STATUS: mmio_rdata = status_word;
      OFF_CYCLE:  mmio_rdata = cycle_count;
      OFF_HALT:   mmio_rdata = {23'b0, halted, exit_code};
      default:    mmio_rdata = '0;
    endcase
  end

  always_comb begin
    memory_out = '0;
    if (aligned) begin
      if (ram_hit)        memory_out = ram_rdata;
      else if (mmio_word) memory_out = mmio_rdata;
    end
  end

  // Cycle counter, halt register and access error flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_count    <= '0;
      halted         <= 1'b0;
      exit_code      <= '0;
      err_misaligned <= 1'b0;
      err_unmapped   <= 1'b0;
    end else begin
      cycle_count <= cycle_wr ? memory_write : cycle_count + 32'd1;
      if (halt_wr && !halted) begin
        halted    <= 1'b1;
        exit_code <= memory_write[7:0];
      end
      if (set_mis) err_misaligned <= 1'b1;
      if (set_unm) err_unmapped   <= 1'b1;
    end
  end

  // Console FIFO: a pop frees the slot a same-cycle push into a full FIFO needs
  assign fifo_full   = (fifo_count == CW'(FIFO_DEPTH));
  assign fifo_empty  = (fifo_count == '0);
  assign fifo_pop    = !fifo_empty && tx_ready;
  assign push_accept = console_push && (!fifo_full || fifo_pop);
  assign count_next  = fifo_count + CW'(push_accept) - CW'(fifo_pop);
  assign tx_data     = fifo_mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) fifo_mem[i] <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      fifo_count    <= '0;
      tx_valid      <= 1'b0;
      fifo_overflow <= 1'b0;
    end else begin
      if (push_accept) begin
        fifo_mem[wr_ptr] <= memory_write[7:0];
        wr_ptr           <= wr_ptr + PW'(1);
      end
      if (fifo_pop) rd_ptr <= rd_ptr + PW'(1);
      fifo_count <= count_next;
      tx_valid   <= (count_next != '0);
      if (console_push && fifo_full && !fifo_pop) fifo_overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_data_memory_responder.sv
// Scoreboard bench for data_memory_responder with a byte-level reference model.
`timescale 1ns/1ps

module tb_data_memory_responder;
  import data_memory_responder_pkg::*;

  localparam int unsigned RAM_WORDS  = 1024;
  localparam int unsigned FIFO_DEPTH = 8;
  localparam logic [31:0] MMIO_BASE  = 32'hFFFF_FF00;
  localparam int unsigned RAM_BYTES  = 4 * RAM_WORDS;
  localparam logic [31:0] A_CONSOLE  = MMIO_BASE;
  localparam logic [31:0] A_STATUS   = MMIO_BASE + 32'd4;
  localparam logic [31:0] A_CYCLE    = MMIO_BASE + 32'd8;
  localparam logic [31:0] A_HALT     = MMIO_BASE + 32'd12;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [31:0]  memory_address = A_CYCLE;
  logic [31:0]  memory_write = '0;
  memory_mask_t memory_mask = MEM_WORD;
  logic         memory_we = 1'b0;
  logic [31:0]  memory_out;
  logic [7:0]   tx_data;
  logic         tx_valid;
  logic         tx_ready = 1'b0;
  logic         halted;
  logic [7:0]   exit_code;
  logic         err_misaligned;
  logic         err_unmapped;
  logic         fifo_overflow;
  logic         rd_req = 1'b0;

  data_memory_responder #(
    .RAM_WORDS(RAM_WORDS), .FIFO_DEPTH(FIFO_DEPTH), .MMIO_BASE(MMIO_BASE)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .memory_address(memory_address), .memory_write(memory_write),
    .memory_mask(memory_mask), .memory_we(memory_we), .memory_out(memory_out),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .halted(halted), .exit_code(exit_code),
    .err_misaligned(err_misaligned), .err_unmapped(err_unmapped),
    .fifo_overflow(fifo_overflow)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [7:0]  m_mem [RAM_BYTES];
  logic [7:0]  m_fifo [$];
  logic [31:0] m_cyc = '0;
  logic        m_halted = 1'b0;
  logic [7:0]  m_exit = '0;
  logic        m_mis = 1'b0;
  logic        m_unm = 1'b0;
  logic        m_ovf = 1'b0;

  // Scoreboard queues
  logic [31:0] exp_rd [$];
  string       exp_name [$];
  logic [7:0]  exp_tx [$];

  int n_cmp  = 0;
  int n_fail = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic int unsigned msize(input memory_mask_t m);
    case (m)
      MEM_BYTE:     return 1;
      MEM_HALFWORD: return 2;
      default:      return 4;
    endcase
  endfunction

  function automatic logic [31:0] status_model();
    int unsigned n = m_fifo.size();
    return 32'((n == FIFO_DEPTH) ? 1 : 0) + 32'((n == 0) ? 2 : 0) + 32'(n * 256)
         + (m_ovf ? 32'h1_0000 : 32'd0) + (m_mis ? 32'h2_0000 : 32'd0)
         + (m_unm ? 32'h4_0000 : 32'd0);
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a, input memory_mask_t m);
    int unsigned sz = msize(m);
    logic [31:0] r = '0;
    if ((a % sz) != 0) return '0;
    if (a < RAM_BYTES) begin
      for (int i = 0; i < int'(sz); i++) r = r | (32'(m_mem[int'(a) + i]) << (8 * i));
    end else if (a >= MMIO_BASE && a < MMIO_BASE + 32'd16 && sz == 4) begin
      case (a - MMIO_BASE)
        32'd4:   r = status_model();
        32'd8:   r = m_cyc;
        32'd12:  r = 32'(m_exit) + (m_halted ? 32'd256 : 32'd0);
        default: r = '0;
      endcase
    end
    return r;
  endfunction

  // One clock edge of the reference model, from the inputs presented this cycle
  task automatic model_step();
    int unsigned sz = msize(memory_mask);
    bit ok = ((memory_address % sz) == 0);
    bit pop = tx_ready && (m_fifo.size() > 0);
    bit push = 1'b0;
    bit cyc_ld = 1'b0;
    if (memory_we) begin
      if (!ok) m_mis = 1'b1;
      else if (memory_address < RAM_BYTES) begin
        for (int i = 0; i < int'(sz); i++)
          m_mem[int'(memory_address) + i] = 8'(memory_write >> (8 * i));
      end else if (memory_address >= MMIO_BASE && memory_address < MMIO_BASE + 32'd16 && sz == 4) begin
        case (memory_address - MMIO_BASE)
          32'd0:  push = 1'b1;
          32'd8:  cyc_ld = 1'b1;
          32'd12: if (!m_halted) begin m_halted = 1'b1; m_exit = memory_write[7:0]; end
          default: ;
        endcase
      end else m_unm = 1'b1;
    end
    m_cyc = cyc_ld ? memory_write : m_cyc + 32'd1;
    if (pop) void'(m_fifo.pop_front());
    if (push) begin
      if (m_fifo.size() < FIFO_DEPTH) begin
        m_fifo.push_back(memory_write[7:0]);
        exp_tx.push_back(memory_write[7:0]);
      end else m_ovf = 1'b1;
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cyc = '0; m_halted = 1'b0; m_exit = '0;
      m_mis = 1'b0; m_unm = 1'b0; m_ovf = 1'b0;
      m_fifo.delete();
      exp_tx.delete();
    end else model_step();
  end

  // Monitor: compares whatever the DUT presents this cycle
  always @(negedge clk) begin
    check("tx_valid", 32'(tx_valid), 32'(m_fifo.size() != 0));
    check("status_outputs", {20'b0, exit_code, halted, err_misaligned, err_unmapped, fifo_overflow},
          {20'b0, m_exit, m_halted, m_mis, m_unm, m_ovf});
    if (tx_valid && tx_ready) begin
      if (exp_tx.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL tx_pop: got byte %h expected no byte (t=%0t)", tx_data, $time);
      end else check("tx_data", 32'(tx_data), 32'(exp_tx.pop_front()));
    end
    if (rd_req) begin
      if (exp_rd.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL read: got %h expected nothing queued (t=%0t)", memory_out, $time);
      end else check(exp_name.pop_front(), memory_out, exp_rd.pop_front());
    end
  end

  task automatic op(input logic [31:0] a, input logic [31:0] d, input memory_mask_t m,
                    input logic we, input logic chk, input logic [31:0] exp, input string name);
    memory_address = a; memory_write = d; memory_mask = m; memory_we = we; rd_req = chk;
    if (chk) begin exp_rd.push_back(exp); exp_name.push_back(name); end
    @(posedge clk); #1;
    memory_we = 1'b0; rd_req = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input memory_mask_t m);
    op(a, d, m, 1'b1, 1'b0, '0, "");
  endtask

  task automatic rd(input logic [31:0] a, input memory_mask_t m, input logic [31:0] exp, input string name);
    op(a, '0, m, 1'b0, 1'b1, exp, name);
  endtask

  task automatic rdm(input logic [31:0] a, input memory_mask_t m, input string name);
    rd(a, m, model_read(a, m), name);
  endtask

  task automatic idle(input int n);
    memory_we = 1'b0; rd_req = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_flags", {27'b0, halted, err_misaligned, err_unmapped, fifo_overflow}, 32'd0);
    check("rst_cycle_read", memory_out, 32'd0);
    rst_n = 1'b1;

    // Byte/halfword lanes and read-during-write
    wr(32'h10, 32'h1122_3344, MEM_WORD);
    wr(32'h11, 32'h0000_00AA, MEM_BYTE);
    wr(32'h12, 32'h0000_BEEF, MEM_HALFWORD);
    rd(32'h10, MEM_WORD, 32'hBEEF_AA44, "lane_word");
    rd(32'h13, MEM_BYTE, 32'h0000_00BE, "lane_byte");
    rd(32'h10, MEM_HALFWORD, 32'h0000_AA44, "lane_half");
    wr(32'h14, 32'h0102_0304, MEM_WORD);
    op(32'h14, 32'h0A0B_0C0D, MEM_WORD, 1'b1, 1'b1, 32'h0102_0304, "rdw_old");
    rd(32'h14, MEM_WORD, 32'h0A0B_0C0D, "rdw_new");

    // Misalignment
    wr(32'h20, 32'h0, MEM_WORD);
    wr(32'h24, 32'h0, MEM_WORD);
    wr(32'h22, 32'hDEAD_BEEF, MEM_WORD);
    check("err_misaligned", 32'(err_misaligned), 32'd1);
    rd(32'h20, MEM_WORD, 32'h0, "mis_unchanged_lo");
    rd(32'h24, MEM_WORD, 32'h0, "mis_unchanged_hi");
    rd(32'h21, MEM_HALFWORD, 32'h0, "mis_read");
    rd(A_STATUS, MEM_WORD, 32'h0002_0002, "status_after_mis");

    // Console FIFO fill, overflow, drain
    tx_ready = 1'b0;
    for (int i = 0; i < 8; i++) wr(A_CONSOLE, 32'h41 + 32'(i), MEM_WORD);
    rd(A_STATUS, MEM_WORD, 32'h0002_0801, "status_full");
    wr(A_CONSOLE, 32'h49, MEM_WORD);
    check("fifo_overflow", 32'(fifo_overflow), 32'd1);
    rd(A_STATUS, MEM_WORD, 32'h0003_0801, "status_overflow");
    tx_ready = 1'b1;
    idle(8);
    check("drained_valid", 32'(tx_valid), 32'd0);
    rd(A_STATUS, MEM_WORD, 32'h0003_0002, "status_drained");

    // Full FIFO with simultaneous push and pop
    tx_ready = 1'b0;
    for (int i = 0; i < 8; i++) wr(A_CONSOLE, 32'h61 + 32'(i), MEM_WORD);
    tx_ready = 1'b1;
    wr(A_CONSOLE, 32'h5A, MEM_WORD);
    rd(A_STATUS, MEM_WORD, 32'h0003_0801, "status_pushpop_full");
    idle(9);
    check("pushpop_drained", 32'(tx_valid), 32'd0);

    // Cycle counter wrap and halt
    wr(A_CYCLE, 32'hFFFF_FFFE, MEM_WORD);
    rd(A_CYCLE, MEM_WORD, 32'hFFFF_FFFE, "cycle_load");
    rd(A_CYCLE, MEM_WORD, 32'hFFFF_FFFF, "cycle_max");
    rd(A_CYCLE, MEM_WORD, 32'h0000_0000, "cycle_wrap");
    wr(A_HALT, 32'h2A, MEM_WORD);
    wr(A_HALT, 32'h07, MEM_WORD);
    check("halted", 32'(halted), 32'd1);
    check("exit_code", 32'(exit_code), 32'h2A);
    rd(A_HALT, MEM_WORD, 32'h0000_012A, "halt_read");

    // Unmapped
    wr(32'h8000_0000, 32'h1234, MEM_WORD);
    check("err_unmapped", 32'(err_unmapped), 32'd1);
    rd(32'h8000_0000, MEM_WORD, 32'h0, "unmapped_read");
    rd(A_STATUS, MEM_WORD, 32'h0007_0002, "status_all_flags");

    // Randomised traffic against the model
    for (int k = 0; k < 64; k++) wr(32'h100 + 32'(4 * k), $urandom, MEM_WORD);
    for (int k = 0; k < 400; k++) begin
      int kind;
      logic [31:0] a;
      memory_mask_t m;
      tx_ready = ($urandom_range(0, 3) == 0);
      kind = int'($urandom_range(0, 9));
      a = 32'h100 + 32'($urandom_range(0, 255));
      m = memory_mask_t'(2'($urandom_range(0, 2)));
      case (kind)
        0, 1, 2, 3: wr(a, $urandom, m);
        4, 5, 6:    rdm(a, m, "rand_ram");
        7:          wr(A_CONSOLE, $urandom, MEM_WORD);
        8:          rdm(A_STATUS, MEM_WORD, "rand_status");
        default:    rdm(A_CYCLE, MEM_WORD, "rand_cycle");
      endcase
    end
    tx_ready = 1'b1;
    idle(12);

    // Asynchronous reset mid-drain
    tx_ready = 1'b0;
    for (int i = 0; i < 3; i++) wr(A_CONSOLE, 32'h71 + 32'(i), MEM_WORD);
    tx_ready = 1'b1;
    idle(1);
    memory_address = A_CYCLE; memory_mask = MEM_WORD;
    #2 rst_n = 1'b0;
    #1;
    check("async_tx_valid", 32'(tx_valid), 32'd0);
    check("async_flags", {27'b0, halted, err_misaligned, err_unmapped, fifo_overflow}, 32'd0);
    check("async_exit_code", 32'(exit_code), 32'd0);
    check("async_cycle", memory_out, 32'd0);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    rd(A_CYCLE, MEM_WORD, 32'd1, "cycle_after_reset");
    rd(32'h10, MEM_WORD, 32'hBEEF_AA44, "ram_kept_after_reset");
    rd(A_STATUS, MEM_WORD, 32'h0000_0002, "status_after_reset");
    idle(2);

    check("rd_queue_empty", 32'(exp_rd.size()), 32'd0);
    check("tx_queue_empty", 32'(exp_tx.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
